flag_cond_unit: RTL and testbench

//  Consumes the ALU flag outputs (negative, zero, overflow, carry_out) in EX.

---
 rtl/flag_cond_unit_if.sv | 29 ++
 rtl/flag_cond_unit.sv | 113 +++++++++++
 tb/tb_flag_cond_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/flag_cond_unit_if.sv
// Signal bundle between the pipeline (master) and the NZCV flag / condition unit (slave).
interface flag_cond_unit_if;
    logic       alu_negative;
    logic       alu_zero;
    logic       alu_overflow;
    logic       alu_carry_out;
    logic       ex_valid;
    logic       ex_set_flags;
    logic       stall;
    logic       flush;
    logic       cond_req;
    logic [3:0] cond_code;
    logic [3:0] flags_q;
    logic       cond_valid;
    logic       cond_true;
    logic       cond_stall;

    modport master (
        output alu_negative, alu_zero, alu_overflow, alu_carry_out,
        output ex_valid, ex_set_flags, stall, flush, cond_req, cond_code,
        input  flags_q, cond_valid, cond_true, cond_stall
    );

    modport slave (
        input  alu_negative, alu_zero, alu_overflow, alu_carry_out,
        input  ex_valid, ex_set_flags, stall, flush, cond_req, cond_code,
        output flags_q, cond_valid, cond_true, cond_stall
    );
endinterface

// File: rtl/flag_cond_unit.sv
// Architectural NZCV register plus B.cond evaluator; the EX->ID flag hazard is
// resolved either by bypassing live ALU flags or by a one-cycle decode stall.
module flag_cond_unit #(
    parameter bit FORWARD = 1'b1
) (
    input logic             clk,
    input logic             reset,
    flag_cond_unit_if.slave bus
);
    logic [3:0] flags_r;
    logic [3:0] live_flags;
    logic [3:0] eval_flags;
    logic       hazard;
    logic       cond_hit;
    logic       valid;
    logic       stall_req;

    assign live_flags = {bus.alu_negative, bus.alu_zero, bus.alu_carry_out, bus.alu_overflow};
    assign hazard     = bus.ex_valid & bus.ex_set_flags;

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_r <= '0;
        end else if (hazard && !bus.stall) begin
            flags_r <= live_flags;
        end
    end

    // f = {N,Z,C,V}
    function automatic logic cond_eval(input logic [3:0] code, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (code)
            4'h0:    return z;
            4'h1:    return !z;
            4'h2:    return c;
            4'h3:    return !c;
            4'h4:    return n;
            4'h5:    return !n;
            4'h6:    return v;
            4'h7:    return !v;
            4'h8:    return c && !z;
            4'h9:    return !c || z;
            4'hA:    return n == v;
            4'hB:    return n != v;
            4'hC:    return !z && (n == v);
            4'hD:    return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    assign cond_hit = cond_eval(bus.cond_code, eval_flags);

    generate
        if (FORWARD) begin : g_bypass
            assign eval_flags = hazard ? live_flags : flags_r;

            always_comb begin
                valid     = bus.cond_req & ~bus.flush & ~reset;
                stall_req = 1'b0;
            end
        end else begin : g_stall
            typedef enum logic {IDLE, WAIT} state_t;
            state_t state, state_next;

            // In WAIT the hazarding write has already landed in flags_r.
            assign eval_flags = flags_r;

            always_ff @(posedge clk) begin
                if (reset) begin
                    state <= IDLE;
                end else if (!bus.stall) begin
                    state <= state_next;
                end
            end

            always_comb begin
                state_next = state;
                valid      = 1'b0;
                stall_req  = 1'b0;
                case (state)
                    IDLE: begin
                        if (bus.cond_req && !bus.flush) begin
                            if (hazard) begin
                                stall_req  = 1'b1;
                                state_next = WAIT;
                            end else begin
                                valid = 1'b1;
                            end
                        end
                    end
                    WAIT: begin
                        valid      = ~bus.flush;
                        state_next = IDLE;
                    end
                    default: state_next = IDLE;
                endcase
                if (reset) begin
                    valid     = 1'b0;
                    stall_req = 1'b0;
                end
            end
        end
    endgenerate

    assign bus.flags_q    = flags_r;
    assign bus.cond_valid = valid;
    assign bus.cond_true  = valid & cond_hit;
    assign bus.cond_stall = stall_req;
endmodule

// File: tb/tb_flag_cond_unit.sv
// Drives a bypass instance and a stall instance with identical stimulus and
// compares both against a behavioural model of the flag/condition rules.
module tb_flag_cond_unit;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    flag_cond_unit_if f_if ();
    flag_cond_unit_if s_if ();

    flag_cond_unit #(.FORWARD(1'b1)) u_fwd (.clk(clk), .reset(reset), .bus(f_if.slave));
    flag_cond_unit #(.FORWARD(1'b0)) u_stl (.clk(clk), .reset(reset), .bus(s_if.slave));

    // model state: architectural flags {N,Z,C,V} and "stall instance owes a result"
    logic [3:0] m_flags;
    logic       m_pend;

    // Base predicates for code pairs; odd codes invert, except 1111 (always).
    function automatic logic ref_cond(input logic [3:0] code, input logic [3:0] f);
        logic n, z, c, v, base;
        int unsigned pair;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        pair = int'(code) / 2;
        case (pair)
            0: base = z;
            1: base = c;
            2: base = n;
            3: base = v;
            4: base = c & ~z;
            5: base = (n == v);
            6: base = (n == v) & ~z;
            default: base = 1'b1;
        endcase
        if (code == 4'hF) return 1'b1;
        return base ^ code[0];
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: apply inputs after negedge, check combinational/registered
    // outputs, then advance the model across the posedge.
    task automatic step(input logic rst, input logic [3:0] alu_nzcv, input logic exv,
                        input logic exs, input logic stl, input logic fl,
                        input logic req, input logic [3:0] code);
        logic       haz, fv, sv, ss;
        logic [3:0] f_eval;
        reset = rst;
        f_if.alu_negative = alu_nzcv[3]; s_if.alu_negative = alu_nzcv[3];
        f_if.alu_zero = alu_nzcv[2];     s_if.alu_zero = alu_nzcv[2];
        f_if.alu_carry_out = alu_nzcv[1]; s_if.alu_carry_out = alu_nzcv[1];
        f_if.alu_overflow = alu_nzcv[0]; s_if.alu_overflow = alu_nzcv[0];
        f_if.ex_valid = exv;     s_if.ex_valid = exv;
        f_if.ex_set_flags = exs; s_if.ex_set_flags = exs;
        f_if.stall = stl;        s_if.stall = stl;
        f_if.flush = fl;         s_if.flush = fl;
        f_if.cond_req = req;     s_if.cond_req = req;
        f_if.cond_code = code;   s_if.cond_code = code;
        #1;
        haz    = exv & exs;
        f_eval = haz ? alu_nzcv : m_flags;
        fv     = ~rst & req & ~fl;
        if (m_pend) begin
            sv = ~rst & ~fl;
            ss = 1'b0;
        end else begin
            sv = ~rst & req & ~fl & ~haz;
            ss = ~rst & req & ~fl & haz;
        end
        chk("fwd_flags", f_if.flags_q, m_flags);
        chk("fwd_valid", {3'b0, f_if.cond_valid}, {3'b0, fv});
        chk("fwd_true",  {3'b0, f_if.cond_true},  {3'b0, fv & ref_cond(code, f_eval)});
        chk("fwd_stall", {3'b0, f_if.cond_stall}, 4'h0);
        chk("stl_flags", s_if.flags_q, m_flags);
        chk("stl_valid", {3'b0, s_if.cond_valid}, {3'b0, sv});
        chk("stl_true",  {3'b0, s_if.cond_true},  {3'b0, sv & ref_cond(code, m_flags)});
        chk("stl_stall", {3'b0, s_if.cond_stall}, {3'b0, ss});
        @(posedge clk);
        if (rst) begin
            m_flags = 4'h0;
            m_pend  = 1'b0;
        end else begin
            if (haz && !stl) m_flags = alu_nzcv;
            if (!stl) m_pend = m_pend ? 1'b0 : ss;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] rcode;
        logic       rreq;
        m_flags = 4'h0;
        m_pend  = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // reset dominates live flag-setting ops
        step(1, 4'hF, 1, 1, 0, 0, 1, 4'h0);
        step(1, 4'hF, 1, 1, 0, 0, 1, 4'h0);
        chk("reset_flags", f_if.flags_q, 4'b0000);

        // SUBS 5-7: N=1 -> LT true, GE false
        step(0, 4'b1000, 1, 1, 0, 0, 0, 4'h0);
        chk("subs_flags", s_if.flags_q, 4'b1000);
        step(0, 4'b0000, 0, 0, 0, 0, 1, 4'hB);
        step(0, 4'b0000, 0, 0, 0, 0, 1, 4'hA);

        // flags_q=0100, then SUBS 3-3 hazards with EQ
        step(0, 4'b0100, 1, 1, 0, 0, 0, 4'h0);
        chk("z_flags", f_if.flags_q, 4'b0100);
        step(0, 4'b0110, 1, 1, 0, 0, 1, 4'h0);
        step(0, 4'b0000, 0, 0, 0, 0, 1, 4'h0);

        // hazard, flush in WAIT, re-request stalls again (back in IDLE)
        step(0, 4'b1001, 1, 1, 0, 0, 1, 4'hC);
        step(0, 4'b0000, 0, 0, 0, 1, 1, 4'hC);
        step(0, 4'b0100, 1, 1, 0, 0, 1, 4'h1);
        // stall held 3 cycles in WAIT: flags and state frozen
        step(0, 4'b1111, 1, 1, 1, 0, 1, 4'h1);
        step(0, 4'b1111, 1, 1, 1, 0, 1, 4'h1);
        step(0, 4'b1111, 1, 1, 1, 0, 1, 4'h1);
        chk("stall_hold_flags", s_if.flags_q, 4'b0100);
        step(0, 4'b0000, 0, 0, 0, 0, 1, 4'h1);

        // non-flag-setting ADD with Z=1 never hazards
        step(0, 4'b0000, 1, 1, 0, 0, 0, 4'h0);
        step(0, 4'b0100, 1, 0, 0, 0, 1, 4'h0);
        step(0, 4'b0100, 1, 0, 0, 0, 1, 4'hE);
        // back-to-back setters: last write wins
        step(0, 4'b0010, 1, 1, 0, 0, 0, 4'h0);
        step(0, 4'b0001, 1, 1, 0, 0, 0, 4'h0);
        chk("last_write", f_if.flags_q, 4'b0001);

        rcode = 4'h0;
        rreq  = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!m_pend) begin
                rcode = 4'($urandom_range(0, 15));
                rreq  = 1'($urandom_range(0, 3) != 0);
            end
            step(1'($urandom_range(0, 49) == 0), 4'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 7) == 0), rreq, rcode);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
